// File: rtl/smc_pkg.sv
// Shared constants and encodings for the MOSFET calculator front end.
package smc_pkg;

  localparam int unsigned N_DEV = 6;
  localparam int unsigned FW    = 3;
  localparam int unsigned OUT_W = 10;
  localparam int unsigned BUS_W = N_DEV * FW;

  // Frame mode encodings understood by the calculator.
  typedef enum logic [1:0] {
    MODE_GM_LO = 2'b00,
    MODE_ID_LO = 2'b01,
    MODE_GM_HI = 2'b10,
    MODE_ID_HI = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    EVAL = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/smc_frame_loader.sv
// Serial-to-parallel device loader for the calculator, with a registered,
// strobed capture of the calculator result.
module smc_frame_loader #(
  parameter int unsigned N_DEV = smc_pkg::N_DEV,
  parameter int unsigned FW    = smc_pkg::FW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                mode_in,
  input  logic [FW-1:0]             W_in,
  input  logic [FW-1:0]             V_GS_in,
  input  logic [FW-1:0]             V_DS_in,
  output logic [1:0]                calc_mode,
  output logic [N_DEV*FW-1:0]       calc_w,
  output logic [N_DEV*FW-1:0]       calc_vgs,
  output logic [N_DEV*FW-1:0]       calc_vds,
  input  logic [smc_pkg::OUT_W-1:0] calc_out_n,
  output logic                      out_valid,
  output logic [smc_pkg::OUT_W-1:0] out_n
);

  import smc_pkg::*;

  localparam int unsigned CNT_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_DEV - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Beats are only taken while the loader is collecting a frame.
  assign accept = in_valid && ((state == IDLE) || (state == LOAD));

  // Frame sequencing, beat counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_n     <= '0;
      calc_mode <= MODE_GM_LO;
    end else begin
      out_valid <= 1'b0;
      out_n     <= '0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            calc_mode <= mode_in;
            if (cnt == LAST_BEAT) begin
              state    <= EVAL;
              cnt      <= '0;
              in_ready <= 1'b0;
            end else begin
              state <= LOAD;
              cnt   <= cnt + CNT_W'(1);
            end
          end
        end
        LOAD: begin
          if (!in_valid) begin
            // Aborted frame: stale slots are overwritten by the next frame.
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == LAST_BEAT) begin
            state    <= EVAL;
            cnt      <= '0;
            in_ready <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        EVAL: begin
          state     <= DONE;
          out_valid <= 1'b1;
          out_n     <= calc_out_n;
        end
        DONE: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Slot register file: the counter addresses the device field being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_w   <= '0;
      calc_vgs <= '0;
      calc_vds <= '0;
    end else if (accept) begin
      for (int k = 0; k < int'(N_DEV); k++) begin
        if (cnt == CNT_W'(k)) begin
          calc_w[k*FW +: FW]   <= W_in;
          calc_vgs[k*FW +: FW] <= V_GS_in;
          calc_vds[k*FW +: FW] <= V_DS_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_smc_frame_loader.sv
// Directed bench for smc_frame_loader with a behavioural calculator stand-in.
module tb_smc_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode_in;
  logic [2:0]  W_in;
  logic [2:0]  V_GS_in;
  logic [2:0]  V_DS_in;
  logic [1:0]  calc_mode;
  logic [17:0] calc_w;
  logic [17:0] calc_vgs;
  logic [17:0] calc_vds;
  logic [9:0]  calc_out_n;
  logic        out_valid;
  logic [9:0]  out_n;

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  exp_n;
  logic [9:0]  ref_a;
  logic [9:0]  ref_b;

  always #5 clk = ~clk;

  // Calculator stand-in: sum of W*(V_GS xor V_DS), post-scaled by mode.
  function automatic logic [9:0] calc_fn(input logic [1:0] m, input logic [17:0] w,
                                         input logic [17:0] g, input logic [17:0] d);
    int unsigned sum;
    sum = 0;
    for (int k = 0; k < 6; k++)
      sum = sum + int'(w[3*k +: 3]) * int'(g[3*k +: 3] ^ d[3*k +: 3]);
    case (m)
      2'b00:   sum = sum >> 1;
      2'b01:   sum = sum;
      2'b10:   sum = sum + 7;
      default: sum = sum * 2;
    endcase
    return 10'(sum);
  endfunction

  assign calc_out_n = calc_fn(calc_mode, calc_w, calc_vgs, calc_vds);

  smc_frame_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode_in    (mode_in),
    .W_in       (W_in),
    .V_GS_in    (V_GS_in),
    .V_DS_in    (V_DS_in),
    .calc_mode  (calc_mode),
    .calc_w     (calc_w),
    .calc_vgs   (calc_vgs),
    .calc_vds   (calc_vds),
    .calc_out_n (calc_out_n),
    .out_valid  (out_valid),
    .out_n      (out_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Six beats; mode_in toggles after beat 0. Expected result queued at the last beat.
  task automatic send_frame(input logic [1:0] m, input logic [17:0] w,
                            input logic [17:0] g, input logic [17:0] d);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      mode_in  = (k == 0) ? m : ~m;
      W_in     = w[3*k +: 3];
      V_GS_in  = g[3*k +: 3];
      V_DS_in  = d[3*k +: 3];
      if (k == 5) exp_q.push_back(calc_fn(m, w, g, d));
      cyc();
    end
    in_valid = 1'b0;
  endtask

  // Result monitor: scoreboard pop on every strobe, zero otherwise.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_n = exp_q.pop_front();
        chk("out_n_sb", 32'(out_n), 32'(exp_n));
      end
    end else begin
      chk("out_n_idle_zero", 32'(out_n), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    mode_in  = 2'b00;
    W_in     = '0;
    V_GS_in  = '0;
    V_DS_in  = '0;
    cyc();
    cyc();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_calc_w", 32'(calc_w), 32'd0);
    chk("rst_calc_mode", 32'(calc_mode), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Basic frame.
    send_frame(2'b01, 18'o111111, 18'o333333, 18'o111111);
    chk("basic_calc_w", 32'(calc_w), 32'(18'o111111));
    chk("basic_t6_ready", 32'(in_ready), 32'd0);
    chk("basic_t6_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("basic_t7_valid", 32'(out_valid), 32'd1);
    chk("basic_t7_out_n", 32'(out_n), 32'd12);
    cyc();
    chk("basic_t8_valid", 32'(out_valid), 32'd0);
    chk("basic_t8_ready", 32'(in_ready), 32'd1);

    // Beat packing and beat-0 mode capture.
    send_frame(2'b10, 18'o654321, 18'o765432, 18'o012345);
    chk("pack_calc_w", 32'(calc_w), 32'(18'o654321));
    chk("pack_calc_vgs", 32'(calc_vgs), 32'(18'o765432));
    chk("pack_calc_vds", 32'(calc_vds), 32'(18'o012345));
    chk("pack_calc_mode", 32'(calc_mode), 32'd2);
    cyc();
    chk("pack_hold_w", 32'(calc_w), 32'(18'o654321));
    cyc();

    // Abort after beat 2, then a full frame.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      mode_in  = 2'b11;
      W_in     = 3'd7;
      V_GS_in  = 3'd5;
      V_DS_in  = 3'd2;
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    chk("abort_ready", 32'(in_ready), 32'd1);
    cyc();
    cyc();
    chk("abort_no_valid", 32'(out_valid), 32'd0);
    send_frame(2'b01, 18'o111111, 18'o333333, 18'o111111);
    chk("abort_refill_w", 32'(calc_w), 32'(18'o111111));
    cyc();
    chk("abort_t7_valid", 32'(out_valid), 32'd1);
    chk("abort_t7_out_n", 32'(out_n), 32'd12);
    cyc();

    // Busy ignore: in_valid held for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      chk("busy_ready", 32'(in_ready), 32'((i == 6 || i == 7) ? 0 : 1));
      chk("busy_valid", 32'(out_valid), 32'((i == 7) ? 1 : 0));
      in_valid = 1'b1;
      V_GS_in  = 3'd3;
      V_DS_in  = 3'd1;
      if (i < 6) begin
        W_in    = 3'(i + 1);
        mode_in = (i == 0) ? 2'b11 : 2'b01;
      end else if (i < 8) begin
        W_in    = 3'd0;
        V_GS_in = 3'd0;
        mode_in = 2'b10;
      end else begin
        W_in    = (i == 8) ? 3'd5 : 3'd2;
        mode_in = (i == 8) ? 2'b00 : 2'b11;
      end
      if (i == 5) exp_q.push_back(calc_fn(2'b11, 18'o654321, 18'o333333, 18'o111111));
      if (i == 7) chk("busy_hold_w", 32'(calc_w), 32'(18'o654321));
      cyc();
    end
    chk("busy_reload_w", 32'(calc_w), 32'(18'o654325));
    chk("busy_reload_mode", 32'(calc_mode), 32'd0);
    chk("busy_reload_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    cyc();
    cyc();

    // Mid-frame asynchronous reset during beat 4.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      mode_in  = 2'b10;
      W_in     = 3'd6;
      V_GS_in  = 3'd4;
      V_DS_in  = 3'd1;
      if (k == 4) begin
        rst_n = 1'b0;
        #2;
        chk("mrst_ready", 32'(in_ready), 32'd1);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_n", 32'(out_n), 32'd0);
        chk("mrst_calc", 32'({calc_mode, calc_w, calc_vgs, calc_vds} != '0), 32'd0);
      end
      cyc();
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("mrst_quiet", 32'(out_valid), 32'd0);
      cyc();
    end
    chk("mrst_idle_ready", 32'(in_ready), 32'd1);

    // Back-to-back frames at T0 and T8.
    ref_a = calc_fn(2'b10, 18'o123456, 18'o777000, 18'o070707);
    ref_b = calc_fn(2'b11, 18'o707070, 18'o135724, 18'o246613);
    send_frame(2'b10, 18'o123456, 18'o777000, 18'o070707);
    cyc();
    chk("b2b_t7_valid", 32'(out_valid), 32'd1);
    chk("b2b_t7_out_n", 32'(out_n), 32'(ref_a));
    cyc();
    send_frame(2'b11, 18'o707070, 18'o135724, 18'o246613);
    chk("b2b_t14_mode", 32'(calc_mode), 32'd3);
    cyc();
    chk("b2b_t15_valid", 32'(out_valid), 32'd1);
    chk("b2b_t15_out_n", 32'(out_n), 32'(ref_b));
    cyc();
    cyc();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
